// File: rtl/shift_pkg.sv
// -----------------------------------------------------------------------------
// shift_pkg -- shared definitions for the shift stage.
//   W        : data width (8)
//   DEPTH    : result buffer depth (2)
//   op_t     : operation encodings (SLL, SRL, SRA, illegal)
//   result_t : one buffered result {y, c, z, n, err}
//   buf_state_t : buffer occupancy; the encoding doubles as the entry count
// -----------------------------------------------------------------------------
package shift_pkg;

    localparam int W     = 8;
    localparam int DEPTH = 2;

    typedef enum logic [1:0] {
        OP_SLL = 2'b00,
        OP_SRL = 2'b01,
        OP_SRA = 2'b10,
        OP_ILL = 2'b11
    } op_t;

    typedef struct packed {
        logic [W-1:0] y;
        logic         c;
        logic         z;
        logic         n;
        logic         err;
    } result_t;

    // Encoded so that the state value is the number of valid entries.
    typedef enum logic [1:0] {
        BUF_EMPTY = 2'd0,
        BUF_ONE   = 2'd1,
        BUF_FULL  = 2'd2
    } buf_state_t;

endpackage

// File: rtl/shift_flags.sv
// -----------------------------------------------------------------------------
// shift_flags -- selects the shifter output for the requested op and derives
// carry, zero, negative and illegal-op flags.
//   a, shamt, op         : request operands
//   sll_y, srl_y, sra_y  : precomputed shifter outputs
//   res                  : packed result {y, c, z, n, err}
// -----------------------------------------------------------------------------
module shift_flags
    import shift_pkg::*;
(
    input  logic [W-1:0] a,
    input  logic [2:0]   shamt,
    input  logic [1:0]   op,
    input  logic [W-1:0] sll_y,
    input  logic [W-1:0] srl_y,
    input  logic [W-1:0] sra_y,
    output result_t      res
);

    // Last bit shifted out: a[8-s] for left shifts, a[s-1] for right shifts.
    // 3-bit wraparound gives 8-s directly; s==0 is masked below so the
    // out-of-range case never reaches the carry.
    logic [2:0] left_idx;
    logic [2:0] right_idx;
    logic       shamt_nz;

    assign left_idx  = 3'd0 - shamt;
    assign right_idx = shamt - 3'd1;
    assign shamt_nz  = (shamt != 3'd0);

    always_comb begin
        res = '0;
        unique case (op_t'(op))
            OP_SLL: begin
                res.y = sll_y;
                res.c = shamt_nz & a[left_idx];
            end
            OP_SRL: begin
                res.y = srl_y;
                res.c = shamt_nz & a[right_idx];
            end
            OP_SRA: begin
                res.y = sra_y;
                res.c = shamt_nz & a[right_idx];
            end
            default: begin
                // Illegal op passes the operand through and raises err.
                res.y   = a;
                res.err = 1'b1;
            end
        endcase
        res.z = (res.y == '0);
        res.n = res.y[W-1];
    end

endmodule

// File: rtl/sll8.sv
// -----------------------------------------------------------------------------
// sll8 -- 8-bit logical left shifter.
//   a : operand, s : shift amount 0..7, y : a << s
// -----------------------------------------------------------------------------
module sll8 (
    input  logic [7:0] a,
    input  logic [2:0] s,
    output logic [7:0] y
);
    assign y = a << s;
endmodule

// File: rtl/sra8.sv
// -----------------------------------------------------------------------------
// sra8 -- 8-bit arithmetic right shifter.
//   a : operand, s : shift amount 0..7, y : a >>> s (sign-filled)
// -----------------------------------------------------------------------------
module sra8 (
    input  logic [7:0] a,
    input  logic [2:0] s,
    output logic [7:0] y
);
    assign y = 8'($signed(a) >>> s);
endmodule

// File: rtl/srl8.sv
// -----------------------------------------------------------------------------
// srl8 -- 8-bit logical right shifter.
//   a : operand, s : shift amount 0..7, y : a >> s (zero-filled)
// -----------------------------------------------------------------------------
module srl8 (
    input  logic [7:0] a,
    input  logic [2:0] s,
    output logic [7:0] y
);
    assign y = a >> s;
endmodule

// File: rtl/shift_stage.sv
// -----------------------------------------------------------------------------
// shift_stage -- valid/ready shift unit with a 2-entry in-order result buffer.
//   clk, rst                     : clock, synchronous active-high reset
//   in_valid/in_ready            : request handshake
//   in_a, in_shamt, in_op        : operand, shift amount, operation
//   out_valid/out_ready          : result handshake
//   out_y, out_c, out_z, out_n, out_err : oldest buffered result and flags
// Results are computed combinationally and written into the buffer on
// acceptance, so a request accepted into an empty buffer is visible right
// after its accepting edge. in_ready depends only on occupancy (and reset),
// never on out_ready.
// -----------------------------------------------------------------------------
module shift_stage
    import shift_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_a,
    input  logic [2:0]   in_shamt,
    input  logic [1:0]   in_op,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_y,
    output logic         out_c,
    output logic         out_z,
    output logic         out_n,
    output logic         out_err
);

    logic [W-1:0] sll_y;
    logic [W-1:0] srl_y;
    logic [W-1:0] sra_y;
    result_t      new_res;

    sll8 u_sll (.a(in_a), .s(in_shamt), .y(sll_y));
    srl8 u_srl (.a(in_a), .s(in_shamt), .y(srl_y));
    sra8 u_sra (.a(in_a), .s(in_shamt), .y(sra_y));

    shift_flags u_flags (
        .a     (in_a),
        .shamt (in_shamt),
        .op    (in_op),
        .sll_y (sll_y),
        .srl_y (srl_y),
        .sra_y (sra_y),
        .res   (new_res)
    );

    // ---------------------------------------------------------------------
    // Result buffer
    // ---------------------------------------------------------------------
    result_t    buf_mem [DEPTH];
    logic       wr_ptr_reg;
    logic       rd_ptr_reg;
    buf_state_t state_reg;
    buf_state_t state_next;
    logic       push;
    logic       pop;
    result_t    head;

    assign in_ready  = (state_reg != BUF_FULL)  && !rst;
    assign out_valid = (state_reg != BUF_EMPTY) && !rst;

    assign push = in_valid  && in_ready;
    assign pop  = out_valid && out_ready;

    always_comb begin
        state_next = state_reg;
        if (push && !pop) begin
            unique case (state_reg)
                BUF_EMPTY: state_next = BUF_ONE;
                BUF_ONE:   state_next = BUF_FULL;
                default:   state_next = state_reg;
            endcase
        end else if (pop && !push) begin
            unique case (state_reg)
                BUF_FULL: state_next = BUF_ONE;
                BUF_ONE:  state_next = BUF_EMPTY;
                default:  state_next = state_reg;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg  <= BUF_EMPTY;
            wr_ptr_reg <= 1'b0;
            rd_ptr_reg <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                buf_mem[i] <= '0;
            end
        end else begin
            state_reg <= state_next;
            if (push) begin
                buf_mem[wr_ptr_reg] <= new_res;
                wr_ptr_reg          <= wr_ptr_reg + 1'b1;
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
        end
    end

    // Head entry only changes on pop, push-into-empty or reset, so the
    // outputs hold steady while the consumer stalls.
    assign head    = buf_mem[rd_ptr_reg];
    assign out_y   = head.y;
    assign out_c   = head.c;
    assign out_z   = head.z;
    assign out_n   = head.n;
    assign out_err = head.err;

endmodule

// File: tb/tb_shift_stage.sv
// -----------------------------------------------------------------------------
// tb_shift_stage -- directed self-checking bench for shift_stage.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_shift_stage;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_a;
    logic [2:0] in_shamt;
    logic [1:0] in_op;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_y;
    logic       out_c;
    logic       out_z;
    logic       out_n;
    logic       out_err;

    int n_cmp = 0;
    int n_bad = 0;

    shift_stage dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_shamt  (in_shamt),
        .in_op     (in_op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_y     (out_y),
        .out_c     (out_c),
        .out_z     (out_z),
        .out_n     (out_n),
        .out_err   (out_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
        in_a = 8'hFF; in_shamt = 3'd1; in_op = 2'b00;
        @(negedge clk);
        n_cmp++;
        if (in_ready !== 1'b0) begin n_bad++; $display("FAIL reset_in_ready: got %b expected 0", in_ready); end
        n_cmp++;
        if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        cycle();
        rst = 1'b0; in_valid = 1'b0;
        #1;
        n_cmp++;
        if (in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_release_in_ready: got %b expected 1", in_ready); end
        n_cmp++;
        if ({out_valid, out_y, out_c, out_z, out_n, out_err} !== 13'h0) begin
            n_bad++;
            $display("FAIL reset_outputs: got v=%b y=%h c=%b z=%b n=%b e=%b expected all 0",
                     out_valid, out_y, out_c, out_z, out_n, out_err);
        end
        $display("reset: done");
    endtask

    // Each row: a, s, op, y, c, z, n, err
    task automatic run_table(input string name, input logic [7:0] a [],
                             input logic [2:0] s [], input logic [1:0] op [],
                             input logic [11:0] exp []);
        for (int i = 0; i < a.size(); i++) begin
            in_a = a[i]; in_shamt = s[i]; in_op = op[i];
            in_valid = 1'b1; out_ready = 1'b1;
            cycle();
            in_valid = 1'b0;
            n_cmp++;
            if (out_valid !== 1'b1) begin
                n_bad++; $display("FAIL %s[%0d]_latency: got out_valid=%b expected 1", name, i, out_valid);
            end
            n_cmp++;
            if ({out_y, out_c, out_z, out_n, out_err} !== exp[i]) begin
                n_bad++;
                $display("FAIL %s[%0d]_result: got y=%h c=%b z=%b n=%b e=%b expected y=%h c=%b z=%b n=%b e=%b",
                         name, i, out_y, out_c, out_z, out_n, out_err,
                         exp[i][11:4], exp[i][3], exp[i][2], exp[i][1], exp[i][0]);
            end
            $display("%s[%0d]: a=%h s=%0d op=%0d -> y=%h c=%b z=%b n=%b e=%b",
                     name, i, a[i], s[i], op[i], out_y, out_c, out_z, out_n, out_err);
            cycle();
            n_cmp++;
            if (out_valid !== 1'b0) begin
                n_bad++; $display("FAIL %s[%0d]_drain: got out_valid=%b expected 0", name, i, out_valid);
            end
        end
    endtask

    task automatic test_shift_s1();
        logic [7:0]  a   [] = '{8'hB3, 8'hB3, 8'hB3};
        logic [2:0]  s   [] = '{3'd1, 3'd1, 3'd1};
        logic [1:0]  op  [] = '{2'b00, 2'b01, 2'b10};
        logic [11:0] exp [] = '{{8'h66, 4'b1000}, {8'h59, 4'b1000}, {8'hD9, 4'b1010}};
        run_table("shift_s1", a, s, op, exp);
    endtask

    task automatic test_shift_s3();
        logic [7:0]  a   [] = '{8'hB3, 8'hB3, 8'hB3};
        logic [2:0]  s   [] = '{3'd3, 3'd3, 3'd3};
        logic [1:0]  op  [] = '{2'b00, 2'b01, 2'b10};
        logic [11:0] exp [] = '{{8'h98, 4'b1010}, {8'h16, 4'b0000}, {8'hF6, 4'b0010}};
        run_table("shift_s3", a, s, op, exp);
    endtask

    task automatic test_flags();
        logic [7:0]  a   [] = '{8'h80, 8'hCA, 8'hCA, 8'h01, 8'h40};
        logic [2:0]  s   [] = '{3'd1, 3'd0, 3'd0, 3'd7, 3'd7};
        logic [1:0]  op  [] = '{2'b00, 2'b10, 2'b00, 2'b00, 2'b01};
        logic [11:0] exp [] = '{{8'h00, 4'b1100}, {8'hCA, 4'b0010}, {8'hCA, 4'b0010},
                                {8'h80, 4'b0010}, {8'h00, 4'b1100}};
        run_table("flags", a, s, op, exp);
    endtask

    task automatic test_illegal();
        logic [7:0]  a   [] = '{8'h5A, 8'h00, 8'hF0};
        logic [2:0]  s   [] = '{3'd5, 3'd2, 3'd3};
        logic [1:0]  op  [] = '{2'b11, 2'b11, 2'b11};
        logic [11:0] exp [] = '{{8'h5A, 4'b0001}, {8'h00, 4'b0101}, {8'hF0, 4'b0011}};
        run_table("illegal", a, s, op, exp);
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b0;
        // A: SLL 0x01 s1 -> 0x02
        in_valid = 1'b1; in_a = 8'h01; in_shamt = 3'd1; in_op = 2'b00;
        cycle();
        n_cmp++;
        if ({in_ready, out_valid, out_y} !== {2'b11, 8'h02}) begin
            n_bad++; $display("FAIL b2b_first: got rdy=%b v=%b y=%h expected rdy=1 v=1 y=02", in_ready, out_valid, out_y);
        end
        // B: SRL 0x80 s2 -> 0x20
        in_a = 8'h80; in_shamt = 3'd2; in_op = 2'b01;
        cycle();
        n_cmp++;
        if (in_ready !== 1'b0) begin n_bad++; $display("FAIL b2b_full_ready: got %b expected 0", in_ready); end
        // C: SRA 0x81 s1 -> 0xC0 c=1, held while full
        in_a = 8'h81; in_shamt = 3'd1; in_op = 2'b10;
        cycle();
        n_cmp++;
        if ({in_ready, out_valid, out_y} !== {2'b01, 8'h02}) begin
            n_bad++; $display("FAIL b2b_stall_hold: got rdy=%b v=%b y=%h expected rdy=0 v=1 y=02", in_ready, out_valid, out_y);
        end
        $display("b2b: stalled head y=%h", out_y);
        out_ready = 1'b1;
        cycle();
        n_cmp++;
        if ({in_ready, out_valid, out_y} !== {2'b11, 8'h20}) begin
            n_bad++; $display("FAIL b2b_second: got rdy=%b v=%b y=%h expected rdy=1 v=1 y=20", in_ready, out_valid, out_y);
        end
        $display("b2b: head y=%h", out_y);
        // C accepted while B is consumed
        cycle();
        in_valid = 1'b0;
        n_cmp++;
        if ({out_valid, out_y, out_c} !== {1'b1, 8'hC0, 1'b1}) begin
            n_bad++; $display("FAIL b2b_third: got v=%b y=%h c=%b expected v=1 y=c0 c=1", out_valid, out_y, out_c);
        end
        $display("b2b: head y=%h", out_y);
        cycle();
        n_cmp++;
        if (out_valid !== 1'b0) begin n_bad++; $display("FAIL b2b_no_dup: got out_valid=%b expected 0", out_valid); end
        cycle();
        n_cmp++;
        if ({out_valid, in_ready} !== 2'b01) begin
            n_bad++; $display("FAIL b2b_idle: got v=%b rdy=%b expected v=0 rdy=1", out_valid, in_ready);
        end
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b0;
        in_valid = 1'b1; in_a = 8'h11; in_shamt = 3'd0; in_op = 2'b00;
        cycle();
        cycle();
        n_cmp++;
        if ({in_ready, out_valid} !== 2'b01) begin
            n_bad++; $display("FAIL rstmid_full: got rdy=%b v=%b expected rdy=0 v=1", in_ready, out_valid);
        end
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        #1;
        n_cmp++;
        if ({in_ready, out_valid} !== 2'b00) begin
            n_bad++; $display("FAIL rstmid_during: got rdy=%b v=%b expected rdy=0 v=0", in_ready, out_valid);
        end
        cycle();
        rst = 1'b0;
        #1;
        n_cmp++;
        if ({in_ready, out_valid, out_y} !== {2'b10, 8'h00}) begin
            n_bad++; $display("FAIL rstmid_after: got rdy=%b v=%b y=%h expected rdy=1 v=0 y=00", in_ready, out_valid, out_y);
        end
        $display("reset_mid: rdy=%b v=%b", in_ready, out_valid);
        // A fresh request after reset must be the only one seen
        @(negedge clk);
        in_valid = 1'b1; in_a = 8'h03; in_shamt = 3'd1; in_op = 2'b00;
        cycle();
        in_valid = 1'b0;
        n_cmp++;
        if ({out_valid, out_y} !== {1'b1, 8'h06}) begin
            n_bad++; $display("FAIL rstmid_fresh: got v=%b y=%h expected v=1 y=06", out_valid, out_y);
        end
        cycle();
        n_cmp++;
        if (out_valid !== 1'b0) begin n_bad++; $display("FAIL rstmid_drained: got v=%b expected 0", out_valid); end
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        in_a = '0; in_shamt = '0; in_op = '0;
        test_reset();
        test_shift_s1();
        test_shift_s3();
        test_flags();
        test_illegal();
        test_back_to_back();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/shift_stage.md
SHIFT_STAGE -- requirements
Module: shift_stage

Interface
REQ-001 The module SHALL have no parameters; data width is fixed at 8 bits and depth at 2 entries, both defined as package constants.
REQ-002 Port clk  input  1  rising-edge clock.
REQ-003 Port rst  input  1  reset; one clock domain; reset is synchronous and active-high.
REQ-004 Port in_valid  input  1  request present.
REQ-005 Port in_ready  output  1  stage can accept a request this cycle.
REQ-006 Port in_a  input  8  operand.
REQ-007 Port in_shamt  input  3  shift amount, 0..7.
REQ-008 Port in_op  input  2  operation: 00 SLL, 01 SRL, 10 SRA, 11 illegal.
REQ-009 Port out_valid  output  1  result present.
REQ-010 Port out_ready  input  1  consumer accepts the result.
REQ-011 Port out_y  output  8  shifted result.
REQ-012 Port out_c  output  1  carry, the last bit shifted out.
REQ-013 Port out_z  output  1  zero flag, set when out_y == 0.
REQ-014 Port out_n  output  1  negative flag, equal to out_y[7].
REQ-015 Port out_err  output  1  illegal op flag.

Function
REQ-016 A request SHALL be accepted on a rising edge when in_valid && in_ready; a result SHALL be consumed when out_valid && out_ready.
REQ-017 The stage SHALL compute the result combinationally from in_* and write {y,c,z,n,err} into a 2-entry in-order result buffer on acceptance.
REQ-018 Latency: a request accepted at edge N with the buffer empty SHALL give out_valid=1 with its result after edge N.
REQ-019 in_ready SHALL be 1 when count < 2; it SHALL be 0 when count == 2, even if out_ready=1 (no combinational ready path).
REQ-020 out_valid SHALL be 1 exactly when count > 0; out_* SHALL show the oldest entry and SHALL stay stable while out_valid && !out_ready.
REQ-021 Simultaneous accept and consume SHALL leave count unchanged and preserve order; with count==1 the new entry becomes head on the next edge.
REQ-022 Result for SLL SHALL be y=a<<s and c=a[8-s]; for SRL y=a>>s and c=a[s-1]; for SRA y=arithmetic shift (sign-filled) and c=a[s-1].
REQ-023 With s=0, y SHALL equal a and c SHALL be 0 for all legal ops.
REQ-024 op=11 SHALL give y=a, c=0, err=1; z and n SHALL still be computed from y; err=0 for legal ops.
REQ-025 Buffer pointers SHALL be 1 bit and wrap 1->0; count is 2 bits, range 0..2.
REQ-026 in_* SHALL be ignored when in_ready=0; out_ready SHALL be ignored when out_valid=0.
REQ-027 The buffer state SHALL take only the values EMPTY (count 0), ONE (count 1) and FULL (count 2), with transitions +1 on accept only and -1 on consume only.

Reset
REQ-028 While rst=1 at an edge: count=0, both pointers=0, out_valid=0 and in_ready=0 during that cycle; out_y/c/z/n/err SHALL be reset to 0.
REQ-029 Reset mid-operation SHALL discard all buffered results; in_ready SHALL be 1 on the first cycle after rst falls.

Structure
REQ-030 Package shift_pkg SHALL hold the op encodings (OP_SLL, OP_SRL, OP_SRA, OP_ILL), constants W=8 and DEPTH=2, and a result struct {y,c,z,n,err}.
REQ-031 The datapath SHALL instantiate the existing sll8, srl8 and sra8 shifters; carry, flag and mux logic stay in a single sub-module shift_flags; buffer control stays in shift_stage.

Verification
REQ-032 Stimulus a=0xB3, s=1, out_ready=1 for SLL/SRL/SRA -> y=0x66/0x59/0xD9, c=1 for all three, one-cycle latency each.
REQ-033 Stimulus a=0xB3, s=3 -> SLL y=0x98 c=1; SRL y=0x16 c=0; SRA y=0xF6 c=0 n=1.
REQ-034 Stimulus a=0x80 SLL s=1 -> y=0x00 z=1 c=1; a=0xCA s=0 SRA -> y=0xCA c=0 n=1 z=0.
REQ-035 Backpressure: out_ready=0, three back-to-back requests -> in_ready falls after the 2nd accept; the 3rd is held; on release, results emerge in order with no loss or duplication.
REQ-036 Stimulus op=11 with a=0x5A -> y=0x5A err=1 c=0; rst asserted with count=2 -> out_valid=0 next cycle and in_ready=1 after rst deasserts.
